// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states and the calculator slave register map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  // Calculator slave register offsets
  localparam logic [31:0] ADDR_OPERAND1 = 32'h0;
  localparam logic [31:0] ADDR_OPERAND2 = 32'h4;
  localparam logic [31:0] ADDR_CONTROL  = 32'h8;
  localparam logic [31:0] ADDR_RESULT   = 32'hC;

  // Calculator control encodings
  localparam logic [1:0] CTRL_AND = 2'b01;
  localparam logic [1:0] CTRL_OR  = 2'b10;
  localparam logic [1:0] CTRL_XOR = 2'b11;

endpackage

// File: rtl/apb_master.sv
// APB requester: one command in, one APB transfer out, one response pulse back.
// A bounded wait on PREADY aborts stuck transfers with a timeout response.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  apb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  // Next-state, bus phase and response decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
          // This edge completes the TIMEOUT_CYCLES-th ACCESS cycle without PREADY
          if (cnt_q >= CntLast) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously by PRESET
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= 32'h0;
      pwdata_q      <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: one instance against a calculator slave model, one with
// TIMEOUT_CYCLES=4 and PREADY tied low.
module tb_apb_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  logic        t_cmd_valid = 1'b0, t_cmd_write = 1'b0;
  logic [31:0] t_cmd_addr = 32'h0, t_cmd_wdata = 32'h0;
  logic        t_cmd_ready, t_rsp_valid, t_rsp_err, t_rsp_timeout;
  logic [31:0] t_rsp_rdata;
  logic        t_psel, t_penable, t_pwrite;
  logic [31:0] t_paddr, t_pwdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master dut (
    .PCLK(pclk), .PRESET(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_master #(.TIMEOUT_CYCLES(4)) dut_to (
    .PCLK(pclk), .PRESET(prst),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(t_cmd_write),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
    .rsp_timeout(t_rsp_timeout),
    .PSEL(t_psel), .PENABLE(t_penable), .PWRITE(t_pwrite), .PADDR(t_paddr),
    .PWDATA(t_pwdata), .PRDATA(32'hA5A5_A5A5), .PREADY(1'b0), .PSLVERR(1'b0)
  );

  // Calculator slave model: registered PREADY that drops only once PSEL drops
  logic        s_ready = 1'b0;
  logic [31:0] s_op1 = 32'h0, s_op2 = 32'h0, s_ctrl = 32'h0, s_res = 32'h0;
  logic        s_bad;
  assign s_bad = !(paddr inside {ADDR_OPERAND1, ADDR_OPERAND2, ADDR_CONTROL, ADDR_RESULT}) ||
                 (pwrite && paddr == ADDR_RESULT);
  assign pready  = s_ready;
  assign pslverr = s_ready && s_bad;
  always_comb begin
    case (paddr)
      ADDR_OPERAND1: prdata = s_op1;
      ADDR_OPERAND2: prdata = s_op2;
      ADDR_CONTROL:  prdata = s_ctrl;
      ADDR_RESULT:   prdata = s_res;
      default:       prdata = 32'hDEAD_BEEF;
    endcase
  end
  always @(posedge pclk) begin
    if (psel && penable && s_ready && pwrite && !s_bad) begin
      case (paddr)
        ADDR_OPERAND1: s_op1 <= pwdata;
        ADDR_OPERAND2: s_op2 <= pwdata;
        ADDR_CONTROL: begin
          s_ctrl <= pwdata;
          case (pwdata[1:0])
            CTRL_AND: s_res <= s_op1 & s_op2;
            CTRL_OR:  s_res <= s_op1 | s_op2;
            CTRL_XOR: s_res <= s_op1 ^ s_op2;
            default:  s_res <= s_res;
          endcase
        end
        default: ;
      endcase
    end
    s_ready <= psel && penable;
  end

  // Bus activity counters for the main instance
  int   psel_cyc = 0, pen_cyc = 0, setups = 0, viol = 0, rsp_seen = 0;
  logic prev_sel = 1'b0, prev_en = 1'b0;
  always @(negedge pclk) begin
    if (psel) psel_cyc++;
    if (penable) pen_cyc++;
    if (psel && !penable) begin
      setups++;
      if (prev_sel && prev_en) viol++;
    end
    if (rsp_valid) rsp_seen++;
    prev_sel = psel;
    prev_en  = penable;
  end

  // Issue one command on the main instance; must be entered just after a negedge.
  // lat counts cycles from the accepting edge to the response cycle.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit hold, output int lat, output logic [31:0] rd,
                      output logic er, output logic tmo);
    int waitc = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge pclk);
      waitc++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
    end
    @(posedge pclk);
    lat = 0;
    do begin
      @(negedge pclk);
      lat++;
      if (lat == 1 && !hold) cmd_valid = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 40);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within 40 cycles for addr %h", a);
    end
    rd  = rsp_rdata;
    er  = rsp_err;
    tmo = rsp_timeout;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pclk);
    checks++;
    if ({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 1000000",
               {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h, required all 0",
               paddr, pwdata, rsp_rdata);
    end
    prst = 1'b0;
  endtask

  task automatic test_single_write();
    int lat;
    logic [31:0] rd;
    logic er, tmo;
    @(negedge pclk);
    psel_cyc = 0;
    pen_cyc  = 0;
    send(1'b1, ADDR_OPERAND1, 32'hF0F0_F0F0, 1'b0, lat, rd, er, tmo);
    #1;
    checks++;
    if (psel_cyc !== 3) begin
      errors++;
      $display("FAIL wr_psel_cycles: got %0d, required 3", psel_cyc);
    end
    checks++;
    if (pen_cyc !== 2) begin
      errors++;
      $display("FAIL wr_penable_cycles: got %0d, required 2", pen_cyc);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wr_latency: got %0d, required 4", lat);
    end
    checks++;
    if ({er, tmo, rd} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL wr_rsp: err=%b tmo=%b rdata=%h, required 0 0 0", er, tmo, rd);
    end
    checks++;
    if (psel !== 1'b0) begin
      errors++;
      $display("FAIL wr_psel_rsp_cycle: got %b, required 0", psel);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    logic er, tmo;
    logic        w_v[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] a_v[4] = '{ADDR_OPERAND2, ADDR_CONTROL, ADDR_CONTROL, ADDR_RESULT};
    logic [31:0] d_v[4] = '{32'hFF00_FF00, 32'h3, 32'h3, 32'h0};
    @(negedge pclk);
    setups = 0;
    viol   = 0;
    for (int i = 0; i < 4; i++) begin
      send(w_v[i], a_v[i], d_v[i], 1'b1, lat, rd, er, tmo);
      checks++;
      if (er !== 1'b0 || lat !== 4) begin
        errors++;
        $display("FAIL b2b_cmd%0d: err=%b lat=%0d, required err=0 lat=4", i, er, lat);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (rd !== 32'h0FF0_0FF0) begin
      errors++;
      $display("FAIL b2b_result: got %h, required 0ff00ff0", rd);
    end
    #1;
    checks++;
    if (setups !== 4 || viol !== 0) begin
      errors++;
      $display("FAIL b2b_psel_gap: setups=%0d access_to_setup=%0d, required 4 and 0",
               setups, viol);
    end
  endtask

  task automatic test_bad_read();
    int lat;
    logic [31:0] rd;
    logic er, tmo;
    @(negedge pclk);
    send(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er, tmo);
    checks++;
    if ({er, tmo, rd} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL bad_read: err=%b tmo=%b rdata=%h, required 1 0 deadbeef", er, tmo, rd);
    end
  endtask

  task automatic test_result_write();
    int lat;
    logic [31:0] rd;
    logic er, tmo;
    @(negedge pclk);
    send(1'b1, ADDR_RESULT, 32'h5555_5555, 1'b0, lat, rd, er, tmo);
    checks++;
    if ({er, tmo, rd} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL result_write: err=%b tmo=%b rdata=%h, required 1 0 0", er, tmo, rd);
    end
    @(negedge pclk);
    send(1'b0, ADDR_RESULT, 32'h0, 1'b0, lat, rd, er, tmo);
    checks++;
    if ({er, rd} !== {1'b0, 32'h0FF0_0FF0}) begin
      errors++;
      $display("FAIL result_unchanged: err=%b rdata=%h, required 0 0ff00ff0", er, rd);
    end
  endtask

  task automatic test_timeout();
    int lat = 0;
    int pen = 0;
    @(negedge pclk);
    t_cmd_valid = 1'b1;
    t_cmd_write = 1'b0;
    t_cmd_addr  = ADDR_RESULT;
    @(posedge pclk);
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) t_cmd_valid = 1'b0;
      if (t_rsp_valid === 1'b1) break;
      if (t_penable === 1'b1) pen++;
    end
    checks++;
    if (t_rsp_valid !== 1'b1 || pen !== 4 || lat !== 6) begin
      errors++;
      $display("FAIL timeout_timing: rsp_valid=%b access=%0d lat=%0d, required 1 4 6",
               t_rsp_valid, pen, lat);
    end
    checks++;
    if ({t_rsp_err, t_rsp_timeout, t_rsp_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL timeout_rsp: err=%b tmo=%b rdata=%h, required 1 1 0",
               t_rsp_err, t_rsp_timeout, t_rsp_rdata);
    end
    checks++;
    if (t_psel !== 1'b0) begin
      errors++;
      $display("FAIL timeout_psel: got %b, required 0", t_psel);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    logic er, tmo;
    @(negedge pclk);
    rsp_seen  = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_OPERAND1;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(posedge pclk);
    #2;
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_access: psel/penable=%b, required 11", {psel, penable});
    end
    prst = 1'b1;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_async: psel/penable/rsp_valid/cmd_ready=%b, required 0001",
               {psel, penable, rsp_valid, cmd_ready});
    end
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b, required 1", cmd_ready);
    end
    repeat (5) @(negedge pclk);
    #1;
    checks++;
    if (rsp_seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_rsp: got %0d responses, required 0", rsp_seen);
    end
    @(negedge pclk);
    send(1'b1, ADDR_OPERAND1, 32'h1234_5678, 1'b0, lat, rd, er, tmo);
    checks++;
    if (er !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL rst_mid_next_wr: err=%b lat=%0d, required 0 4", er, lat);
    end
    @(negedge pclk);
    send(1'b0, ADDR_OPERAND1, 32'h0, 1'b0, lat, rd, er, tmo);
    checks++;
    if ({er, rd} !== {1'b0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rst_mid_next_rd: err=%b rdata=%h, required 0 12345678", er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_read();
    test_result_write();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-word commands from a local command port into APB transfers, then returns read data and error status on a response port. It drives the same APB bus as the team's calculator register slave: operand1 at 0x0, operand2 at 0x4, control at 0x8, and the read-only result at 0xC. This lets a CPU-side model or test sequencer reach the slave without hand-driving bus phases. It runs one transfer at a time, with a bounded wait on PREADY.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles to wait for PREADY before aborting; must be ≥1.
- PCLK  in  1  bus and block clock.
- PRESET  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid at PCLK edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse; response fields are valid.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Always go to ACCESS on the next edge.
  - Clear the wait counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=1 at an edge, the transfer completes:
    - capture PRDATA (reads only) and PSLVERR;
    - pulse rsp_valid next cycle;
    - go to IDLE.
  - Otherwise increment the wait counter.
  - If the counter reaches TIMEOUT_CYCLES without PREADY, go to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Every transfer returns to IDLE with PSEL=0 for at least one cycle. Back-to-back SETUP from ACCESS is forbidden, because the slave releases PREADY only when PSEL drops; holding PSEL would complete the next transfer on stale PREADY.
- PADDR, PWDATA and PWRITE stay stable from SETUP through ACCESS and hold their last value in IDLE.
- rsp_rdata, rsp_err and rsp_timeout hold until the next response. rsp_valid carries no backpressure: the consumer must take it that cycle.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- PSLVERR and PRDATA are sampled only on the completing edge (PREADY=1 in ACCESS).

## Timing
- All outputs are registered, except cmd_ready, which decodes state==IDLE.
- Reset values:
  - state IDLE, cmd_ready=1;
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
  - wait counter 0.
- Cycle schedule, with acceptance at edge E0:
  - SETUP in E0→E1;
  - ACCESS from E1;
  - the slave's registered PREADY rises after E2 and is sampled at E3;
  - rsp_valid and PSEL=0 in E3→E4.
  - Transfer-to-response latency is 4 cycles against the calculator slave; the minimum with a zero-wait slave is 3.
- Next acceptance is at E4 at the earliest, so the command interval is ≥4 cycles.
- Reset asserted mid-transfer:
  - all outputs clear immediately (async);
  - no rsp_valid is issued for the aborted command;
  - cmd_ready=1 on the first cycle after release.
- PREADY=1 during IDLE or SETUP is ignored.

## Structure
- Shared package apb_pkg holds:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS};
  - calculator register offsets ADDR_OPERAND1=32'h0, ADDR_OPERAND2=32'h4, ADDR_CONTROL=32'h8, ADDR_RESULT=32'hC;
  - control encodings CTRL_AND=2'b01, CTRL_OR=2'b10, CTRL_XOR=2'b11.
- Single module, no sub-module. The wait counter is inline.

## Test plan
- Write 0x0=32'hF0F0_F0F0 to the calculator slave:
  - PSEL high exactly 3 cycles;
  - PENABLE high 2 cycles;
  - rsp_valid 4 cycles after acceptance;
  - rsp_err=0.
- Ordered sequence with cmd_valid held high throughout:
  - commands: write 0x4=32'hFF00_FF00, write 0x8=3, write 0x8=3, read 0xC;
  - rsp_rdata=32'h0FF0_0FF0;
  - PSEL low ≥1 cycle between every transfer.
- Read 0x10: rsp_err=1, rsp_timeout=0, rsp_rdata=32'hDEAD_BEEF.
- Write 0xC: rsp_err=1, and a subsequent read of 0xC returns an unchanged result.
- TIMEOUT_CYCLES=4 with PREADY tied 0:
  - rsp_valid after 4 ACCESS cycles;
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0;
  - PSEL=0 in the response cycle.
- PRESET pulsed during ACCESS:
  - PSEL and PENABLE drop asynchronously;
  - no rsp_valid;
  - the next command completes normally.
